memory_stage: RTL and testbench

//  Y86-64 memory stage. Sits directly downstream of execute: consumes icode, valE, valA, valP.

---
 rtl/y86_pkg.sv | 41 ++++
 rtl/memory_stage_if.sv | 23 ++
 rtl/mem_access_decode.sv | 41 ++++
 rtl/memory_stage.sv | 138 +++++++++++++
 tb/tb_memory_stage.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, memory-stage FSM
// states and the decoded data-memory access payload.
package y86_pkg;

  localparam int unsigned ICODE_W = 4;
  localparam int unsigned WORD_W  = 64;
  localparam int unsigned STAT_W  = 3;

  localparam logic [ICODE_W-1:0] IHALT   = 4'h0;
  localparam logic [ICODE_W-1:0] INOP    = 4'h1;
  localparam logic [ICODE_W-1:0] IRRMOVQ = 4'h2;
  localparam logic [ICODE_W-1:0] IIRMOVQ = 4'h3;
  localparam logic [ICODE_W-1:0] IRMMOVQ = 4'h4;
  localparam logic [ICODE_W-1:0] IMRMOVQ = 4'h5;
  localparam logic [ICODE_W-1:0] IOPQ    = 4'h6;
  localparam logic [ICODE_W-1:0] IJXX    = 4'h7;
  localparam logic [ICODE_W-1:0] ICALL   = 4'h8;
  localparam logic [ICODE_W-1:0] IRET    = 4'h9;
  localparam logic [ICODE_W-1:0] IPUSHQ  = 4'hA;
  localparam logic [ICODE_W-1:0] IPOPQ   = 4'hB;

  localparam logic [STAT_W-1:0] SAOK = 3'd1;
  localparam logic [STAT_W-1:0] SHLT = 3'd2;
  localparam logic [STAT_W-1:0] SADR = 3'd3;
  localparam logic [STAT_W-1:0] SINS = 3'd4;

  typedef enum logic [1:0] {
    MS_IDLE   = 2'd0,
    MS_CHECK  = 2'd1,
    MS_ACCESS = 2'd2,
    MS_FIN    = 2'd3
  } ms_state_e;

  typedef struct packed {
    logic              needs_access;
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_access_t;

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory req/ack bus between the memory stage (master) and data memory (slave).
interface memory_stage_if;
  import y86_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_err;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata, mem_err
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata, mem_err
  );

endinterface

// File: rtl/mem_access_decode.sv
// Combinational map from icode and operands to the data-memory access
// (whether one is needed, direction, address, write data).
module mem_access_decode
  import y86_pkg::*;
(
  input  logic [ICODE_W-1:0] icode,
  input  logic [WORD_W-1:0]  valE,
  input  logic [WORD_W-1:0]  valA,
  input  logic [WORD_W-1:0]  valP,
  output mem_access_t        acc_c
);

  always_comb begin
    acc_c = '0;
    case (icode)
      IRMMOVQ, IPUSHQ: begin
        acc_c.needs_access = 1'b1;
        acc_c.we           = 1'b1;
        acc_c.addr         = valE;
        acc_c.wdata        = valA;
      end
      ICALL: begin
        acc_c.needs_access = 1'b1;
        acc_c.we           = 1'b1;
        acc_c.addr         = valE;
        acc_c.wdata        = valP;
      end
      IMRMOVQ: begin
        acc_c.needs_access = 1'b1;
        acc_c.addr         = valE;
      end
      // Stack pops read from the old stack pointer carried in valA.
      IRET, IPOPQ: begin
        acc_c.needs_access = 1'b1;
        acc_c.addr         = valA;
      end
      default: acc_c = '0;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 memory stage: status check, req/ack data-memory access with timeout,
// one-cycle done pulse. Optional address bounds check under MEM_BOUNDS_CHECK_EN.
module memory_stage
  import y86_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
`ifdef MEM_BOUNDS_CHECK_EN
  ,
  parameter logic [63:0] ADDR_LIMIT     = 64'h1000
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ICODE_W-1:0]  icode,
  input  logic [WORD_W-1:0]   valE,
  input  logic [WORD_W-1:0]   valA,
  input  logic [WORD_W-1:0]   valP,
  input  logic                instr_valid,
  input  logic                imem_error,
  memory_stage_if.master      mem,
  output logic                busy,
  output logic                done,
  output logic [WORD_W-1:0]   valM,
  output logic [STAT_W-1:0]   stat
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  ms_state_e         state;
  mem_access_t       acc_c;
  logic              needs_q;
  logic              imem_error_q;
  logic              instr_valid_q;
  logic              halt_q;
  logic [CNT_W-1:0]  cnt;
  logic [STAT_W-1:0] check_stat_c;

  mem_access_decode u_decode (
    .icode (icode),
    .valE  (valE),
    .valA  (valA),
    .valP  (valP),
    .acc_c (acc_c)
  );

  // Status precedence evaluated on the instruction latched at start.
  always_comb begin
    check_stat_c = SAOK;
    if (imem_error_q) begin
      check_stat_c = SADR;
    end else if (!instr_valid_q) begin
      check_stat_c = SINS;
    end else if (halt_q) begin
      check_stat_c = SHLT;
    end
`ifdef MEM_BOUNDS_CHECK_EN
    // 65-bit end address makes an addr+7 wrap count as out of bounds.
    else if (needs_q &&
             ((mem.mem_addr >= ADDR_LIMIT) ||
              (({1'b0, mem.mem_addr} + 65'd7) > {1'b0, ADDR_LIMIT - 64'd1}))) begin
      check_stat_c = SADR;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= MS_IDLE;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      valM          <= '0;
      stat          <= SAOK;
      needs_q       <= 1'b0;
      imem_error_q  <= 1'b0;
      instr_valid_q <= 1'b0;
      halt_q        <= 1'b0;
      cnt           <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MS_IDLE: begin
          if (start) begin
            state         <= MS_CHECK;
            busy          <= 1'b1;
            mem.mem_addr  <= acc_c.addr;
            mem.mem_wdata <= acc_c.wdata;
            mem.mem_we    <= acc_c.we;
            needs_q       <= acc_c.needs_access;
            imem_error_q  <= imem_error;
            instr_valid_q <= instr_valid;
            halt_q        <= (icode == IHALT);
          end
        end
        MS_CHECK: begin
          cnt <= '0;
          if (check_stat_c == SAOK && needs_q) begin
            state       <= MS_ACCESS;
            mem.mem_req <= 1'b1;
          end else begin
            state <= MS_FIN;
            done  <= 1'b1;
            stat  <= check_stat_c;
            valM  <= '0;
          end
        end
        MS_ACCESS: begin
          // An ack in the timeout cycle still completes the access normally.
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            state       <= MS_FIN;
            done        <= 1'b1;
            stat        <= mem.mem_err ? SADR : SAOK;
            valM        <= mem.mem_we ? '0 : mem.mem_rdata;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES)) begin
            mem.mem_req <= 1'b0;
            state       <= MS_FIN;
            done        <= 1'b1;
            stat        <= SADR;
            valM        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        MS_FIN: begin
          state <= MS_IDLE;
          busy  <= 1'b0;
        end
        default: state <= MS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage; MEM_BOUNDS_CHECK_EN selects
// the expected result of the out-of-bounds vector.
module tb_memory_stage;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valE, valA, valP;
  logic        instr_valid, imem_error;
  logic        busy, done;
  logic [63:0] valM;
  logic [2:0]  stat;

  memory_stage_if mif ();

  memory_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .icode       (icode),
    .valE        (valE),
    .valA        (valA),
    .valP        (valP),
    .instr_valid (instr_valid),
    .imem_error  (imem_error),
    .mem         (mif),
    .busy        (busy),
    .done        (done),
    .valM        (valM),
    .stat        (stat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          r_done_k;
  int          r_req_cycles;
  int          r_ndone;
  logic [63:0] r_addr, r_wdata;
  logic        r_we;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one instruction, acts as the data memory, and records what happened.
  // ack_delay < 0 means never ack; restart_at > 0 pulses a halt start at that cycle.
  task automatic run_op(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                        input logic [63:0] p, input logic v, input logic im,
                        input int ack_delay, input logic [63:0] rd, input logic err,
                        input int restart_at);
    r_done_k = -1; r_req_cycles = 0; r_ndone = 0;
    r_addr = 'x; r_wdata = 'x; r_we = 1'bx;
    @(negedge clk);
    start = 1'b1; icode = ic; valE = e; valA = a; valP = p;
    instr_valid = v; imem_error = im;
    mif.mem_rdata = rd; mif.mem_err = err;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == restart_at) begin
        start = 1'b1; icode = IHALT; instr_valid = 1'b1; imem_error = 1'b0;
      end
      mif.mem_ack = 1'b0;
      if (mif.mem_req) begin
        if (r_req_cycles == 0) begin
          r_addr = mif.mem_addr; r_wdata = mif.mem_wdata; r_we = mif.mem_we;
        end
        if (ack_delay >= 0 && r_req_cycles == ack_delay) mif.mem_ack = 1'b1;
        r_req_cycles++;
      end
      if (done) begin
        r_ndone++;
        if (r_done_k < 0) r_done_k = k;
      end
      if (r_done_k >= 0 && k >= r_done_k + 3) break;
    end
    mif.mem_ack = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; icode = '0; valE = '0; valA = '0; valP = '0;
    instr_valid = 1'b1; imem_error = 1'b0;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0; mif.mem_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_mem_req", 64'(mif.mem_req), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_stat", 64'(stat), 64'(SAOK));
    chk("reset_valM", valM, 64'd0);
    chk("reset_addr", mif.mem_addr, 64'd0);
    rst_n = 1'b1;

    // mrmovq: immediate ack, read data captured
    run_op(IMRMOVQ, 64'h80, 64'h0, 64'h0, 1'b1, 1'b0, 0, 64'hDEADBEEF, 1'b0, 0);
    chk("mrmovq_addr", r_addr, 64'h80);
    chk("mrmovq_we", 64'(r_we), 64'd0);
    chk("mrmovq_valM", valM, 64'hDEADBEEF);
    chk("mrmovq_stat", 64'(stat), 64'(SAOK));
    chk("mrmovq_latency", 64'(r_done_k), 64'd3);
    chk("mrmovq_busy_after", 64'(busy), 64'd0);

    // rmmovq: ack after 2 waiting cycles, valM cleared
    run_op(IRMMOVQ, 64'h100, 64'h456, 64'h0, 1'b1, 1'b0, 2, 64'h1234, 1'b0, 0);
    chk("rmmovq_we", 64'(r_we), 64'd1);
    chk("rmmovq_addr", r_addr, 64'h100);
    chk("rmmovq_wdata", r_wdata, 64'h456);
    chk("rmmovq_stat", 64'(stat), 64'(SAOK));
    chk("rmmovq_valM", valM, 64'd0);
    chk("rmmovq_latency", 64'(r_done_k), 64'd5);
    chk("rmmovq_req_cycles", 64'(r_req_cycles), 64'd3);
    chk("rmmovq_ndone", 64'(r_ndone), 64'd1);

    // ret: reads from valA
    run_op(IRET, 64'h208, 64'h200, 64'h0, 1'b1, 1'b0, 1, 64'h7777, 1'b0, 0);
    chk("ret_addr", r_addr, 64'h200);
    chk("ret_we", 64'(r_we), 64'd0);
    chk("ret_valM", valM, 64'h7777);

    // popq: reads from valA as well
    run_op(IPOPQ, 64'h308, 64'h300, 64'h0, 1'b1, 1'b0, 0, 64'h99, 1'b0, 0);
    chk("popq_addr", r_addr, 64'h300);
    chk("popq_valM", valM, 64'h99);

    // call: writes valP to valE
    run_op(ICALL, 64'h1F8, 64'h11, 64'h4321, 1'b1, 1'b0, 0, 64'h0, 1'b0, 0);
    chk("call_addr", r_addr, 64'h1F8);
    chk("call_wdata", r_wdata, 64'h4321);
    chk("call_we", 64'(r_we), 64'd1);

    // pushq: writes valA to valE
    run_op(IPUSHQ, 64'h2F8, 64'h55, 64'h66, 1'b1, 1'b0, 0, 64'h0, 1'b0, 0);
    chk("pushq_wdata", r_wdata, 64'h55);

    // opq: no access, two-cycle latency
    run_op(IOPQ, 64'h100, 64'h1, 64'h2, 1'b1, 1'b0, 0, 64'h0, 1'b0, 0);
    chk("opq_req", 64'(r_req_cycles), 64'd0);
    chk("opq_latency", 64'(r_done_k), 64'd2);
    chk("opq_stat", 64'(stat), 64'(SAOK));

    // Status precedence, none may raise mem_req
    run_op(IHALT, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 0, 64'h0, 1'b0, 0);
    chk("halt_stat", 64'(stat), 64'(SHLT));
    chk("halt_req", 64'(r_req_cycles), 64'd0);
    run_op(IMRMOVQ, 64'h80, 64'h0, 64'h0, 1'b0, 1'b0, 0, 64'h0, 1'b0, 0);
    chk("ins_stat", 64'(stat), 64'(SINS));
    chk("ins_req", 64'(r_req_cycles), 64'd0);
    run_op(IHALT, 64'h80, 64'h0, 64'h0, 1'b0, 1'b1, 0, 64'h0, 1'b0, 0);
    chk("imem_stat", 64'(stat), 64'(SADR));
    chk("imem_req", 64'(r_req_cycles), 64'd0);

    // Timeout: req held TIMEOUT_CYCLES+1 cycles
    run_op(IMRMOVQ, 64'h40, 64'h0, 64'h0, 1'b1, 1'b0, -1, 64'hABCD, 1'b0, 0);
    chk("timeout_req_cycles", 64'(r_req_cycles), 64'd256);
    chk("timeout_stat", 64'(stat), 64'(SADR));
    chk("timeout_valM", valM, 64'd0);
    chk("timeout_latency", 64'(r_done_k), 64'd258);

    // Ack in the final timeout cycle still completes normally
    run_op(IMRMOVQ, 64'h48, 64'h0, 64'h0, 1'b1, 1'b0, 255, 64'h5A5A, 1'b0, 0);
    chk("late_ack_stat", 64'(stat), 64'(SAOK));
    chk("late_ack_valM", valM, 64'h5A5A);

    // mem_err with ack
    run_op(IRMMOVQ, 64'h10, 64'h1, 64'h0, 1'b1, 1'b0, 0, 64'h0, 1'b1, 0);
    chk("memerr_stat", 64'(stat), 64'(SADR));

    // start while busy is ignored
    run_op(IMRMOVQ, 64'h88, 64'h0, 64'h0, 1'b1, 1'b0, 3, 64'hC0FFEE, 1'b0, 2);
    chk("busy_start_ndone", 64'(r_ndone), 64'd1);
    chk("busy_start_stat", 64'(stat), 64'(SAOK));
    chk("busy_start_valM", valM, 64'hC0FFEE);
    chk("busy_start_idle", 64'(busy), 64'd0);

    // Bounds: 0xFFC + 7 crosses 0xFFF
    run_op(IRMMOVQ, 64'hFFC, 64'h1, 64'h0, 1'b1, 1'b0, 0, 64'h0, 1'b0, 0);
`ifdef MEM_BOUNDS_CHECK_EN
    chk("bounds_stat", 64'(stat), 64'(SADR));
    chk("bounds_req", 64'(r_req_cycles), 64'd0);
`else
    chk("bounds_stat", 64'(stat), 64'(SAOK));
    chk("bounds_addr", r_addr, 64'hFFC);
`endif

    // Reset mid-access drops mem_req without a clock edge
    @(negedge clk);
    start = 1'b1; icode = IRMMOVQ; valE = 64'h100; valA = 64'h1;
    instr_valid = 1'b1; imem_error = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rst_mid_req_before", 64'(mif.mem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_req_after", 64'(mif.mem_req), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    mif.mem_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mif.mem_ack = 1'b0;
    @(negedge clk);
    chk("rst_ack_ignored_done", 64'(done), 64'd0);
    chk("rst_ack_ignored_busy", 64'(busy), 64'd0);
    chk("rst_ack_ignored_req", 64'(mif.mem_req), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
